// File: rtl/cpeta_eval_pkg.sv
// Shared definitions for the CPETA error-evaluation engine.
package cpeta_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_t;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          DRAIN_CYC = 2;
  localparam int          DRAIN_W   = 2;

endpackage

// File: rtl/cpeta.sv
// CPETA approximate adder: K-bit segments added independently, each segment's
// carry-in predicted as the generate of the top bit of the segment below.
module cpeta #(
  parameter int N = 16,
  parameter int K = 6
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] sum
);

  localparam int NSEG = (N + K - 1) / K;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    localparam int LO = g * K;
    localparam int HI = ((g + 1) * K < N) ? (g + 1) * K - 1 : N - 1;
    localparam int W  = HI - LO + 1;

    logic w_cin;

    if (g == 0) begin : g_first
      assign w_cin = 1'b0;
    end else begin : g_pred
      assign w_cin = A[LO-1] & B[LO-1];
    end

    // Segment carry-out is dropped; only the prediction crosses segments.
    assign sum[HI:LO] = A[HI:LO] + B[HI:LO] + W'(w_cin);
  end

endmodule

// File: rtl/cpeta_eval_lfsr.sv
// 32-bit right-shift Galois LFSR with seed load; a zero seed is forced to 1
// so the generator can never lock up in the all-zero state.
module cpeta_eval_lfsr
  import cpeta_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_adv,
  output logic [LFSR_W-1:0] o_q
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_next;

  assign w_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_W'(1);
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
    end else if (i_adv) begin
      r_lfsr <= w_next;
    end
  end

  assign o_q = r_lfsr;

endmodule

// File: rtl/cpeta_err_eval_ctrl.sv
// Streams LFSR operand pairs through CPETA and an exact adder and accumulates
// error count, saturating total error distance and maximum error distance.
module cpeta_err_eval_ctrl
  import cpeta_eval_pkg::*;
#(
  parameter int N     = 16,
  parameter int K     = 6,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed
);

  eval_state_t        r_state;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_remain;
  logic [DRAIN_W-1:0] r_drain;

  logic               w_accept;
  logic               w_issue;
  logic [LFSR_W-1:0]  w_lfsr;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_issue  = (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_remain <= '0;
      r_drain  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remain <= num_samples;
            if (num_samples == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_remain <= r_remain - 1'b1;
          if (r_remain == CNT_W'(1)) begin
            r_state <= ST_DRAIN;
            r_drain <= DRAIN_W'(DRAIN_CYC - 1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  cpeta_eval_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_seed (seed),
    .i_adv  (w_issue),
    .o_q    (w_lfsr)
  );

  logic         r_v0, r_v1;
  logic [N-1:0] r_x, r_y, r_s, r_e;
  logic [N-1:0] w_s_apx;
  logic [N-1:0] w_s_exact;
  logic [N-1:0] w_ed;

  cpeta #(.N(N), .K(K)) u_cpeta (
    .A   (r_x),
    .B   (r_y),
    .sum (w_s_apx)
  );

  assign w_s_exact = r_x + r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else begin
      r_v0 <= w_issue;
      r_v1 <= r_v0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_x <= w_lfsr[16+N-1:16];
      r_y <= w_lfsr[N-1:0];
    end
    if (r_v0) begin
      r_s <= w_s_apx;
      r_e <= w_s_exact;
    end
  end

  assign w_ed = (r_s >= r_e) ? (r_s - r_e) : (r_e - r_s);

  logic [CNT_W-1:0] r_err_count;
  logic [ACC_W-1:0] r_sum_ed;
  logic [N-1:0]     r_max_ed;
  logic [ACC_W:0]   w_sum_wide;

  // One extra bit catches overflow so the total pins at all-ones.
  assign w_sum_wide = {1'b0, r_sum_ed} + (ACC_W+1)'(w_ed);

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_err_count <= '0;
      r_sum_ed    <= '0;
      r_max_ed    <= '0;
    end else if (r_v1) begin
      if (w_ed != '0) begin
        r_err_count <= r_err_count + 1'b1;
      end
      r_sum_ed <= w_sum_wide[ACC_W] ? '1 : w_sum_wide[ACC_W-1:0];
      if (w_ed > r_max_ed) begin
        r_max_ed <= w_ed;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err_count;
  assign sum_ed    = r_sum_ed;
  assign max_ed    = r_max_ed;

endmodule
